// File: rtl/cbs_pkg.sv
// Shared definitions for the 3x3 convolution MAC: default widths, tap count,
// FSM state encoding and output saturation limits.
package cbs_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned W_W_DEF        = 8;
  localparam int unsigned ACC_W_DEF      = 24;
  localparam int unsigned SHIFT_DEF      = 8;
  localparam int unsigned IMG_PIXELS_DEF = 409600;

  localparam int unsigned NUM_TAPS = 9;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH,
    OUT
  } state_t;

endpackage

// File: rtl/conv_weight_rf.sv
// Weight/bias register file for the 3x3 MAC.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (clears all entries)
//   w_we_i/w_addr_i/w_data_i : weight write (addresses above 8 are ignored)
//   b_we_i/b_data_i    : bias write
//   rd_idx_i           : tap index for the combinational weight read
//   w_rd_o_c           : weight at rd_idx_i (zero when index is out of range)
//   bias_o             : current bias
module conv_weight_rf
  import cbs_pkg::*;
#(
  parameter int unsigned W_W   = W_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_we_i,
  input  logic [3:0]              w_addr_i,
  input  logic signed [W_W-1:0]   w_data_i,
  input  logic                    b_we_i,
  input  logic signed [ACC_W-1:0] b_data_i,
  input  logic [3:0]              rd_idx_i,
  output logic signed [W_W-1:0]   w_rd_o_c,
  output logic signed [ACC_W-1:0] bias_o
);

  logic signed [W_W-1:0]   w_q [NUM_TAPS];
  logic signed [ACC_W-1:0] bias_q;

  // Weight and bias storage; both writes may land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        w_q[i] <= '0;
      end
      bias_q <= '0;
    end else begin
      if (w_we_i && (w_addr_i < 4'(NUM_TAPS))) begin
        w_q[w_addr_i] <= w_data_i;
      end
      if (b_we_i) begin
        bias_q <= b_data_i;
      end
    end
  end

  assign w_rd_o_c = (rd_idx_i < 4'(NUM_TAPS)) ? w_q[rd_idx_i] : '0;
  assign bias_o   = bias_q;

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution multiply-accumulate with bias, floor shift and int8 saturation.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   pix_in/tap_idx/pix_valid    : pixel stream with tap index; pix_ready accepts
//   w_load/w_addr/w_data        : weight write (honoured only in IDLE)
//   b_load/b_data               : bias write (honoured only in IDLE)
//   res_data/res_valid/res_ready: result handshake
//   frame_done                  : one-cycle pulse after the last window of a frame
//   sat_flag, seq_err           : sticky status flags
module conv3x3_mac
  import cbs_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned W_W        = W_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned SHIFT      = SHIFT_DEF,
  parameter int unsigned IMG_PIXELS = IMG_PIXELS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       pix_in,
  input  logic [3:0]              tap_idx,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    w_load,
  input  logic [3:0]              w_addr,
  input  logic signed [W_W-1:0]   w_data,
  input  logic                    b_load,
  input  logic signed [ACC_W-1:0] b_data,
  output logic signed [7:0]       res_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    frame_done,
  output logic                    sat_flag,
  output logic                    seq_err
);

  localparam int unsigned PROD_W = DATA_W + 1 + W_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned CNT_W  = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]              exp_tap_q, exp_tap_d;
  logic [CNT_W-1:0]        win_cnt_q, win_cnt_d;
  logic signed [7:0]       res_data_q, res_data_d;
  logic                    res_valid_q, res_valid_d;
  logic                    pix_ready_q, pix_ready_d;
  logic                    frame_done_q, frame_done_d;
  logic                    sat_q, sat_d;
  logic                    seq_err_q, seq_err_d;

  logic signed [W_W-1:0]    w_rd_c;
  logic signed [ACC_W-1:0]  bias_c;
  logic                     cfg_en_c, accept_c, hs_c;
  logic signed [PROD_W-1:0] pix_s_c, w_s_c, prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;
  logic signed [SUM_W-1:0]  sum_c, shifted_c;

  assign cfg_en_c = (state_q == IDLE);
  assign accept_c = pix_valid & pix_ready_q;
  assign hs_c     = res_valid_q & res_ready;

  conv_weight_rf #(
    .W_W  (W_W),
    .ACC_W(ACC_W)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .w_we_i  (w_load & cfg_en_c),
    .w_addr_i(w_addr),
    .w_data_i(w_data),
    .b_we_i  (b_load & cfg_en_c),
    .b_data_i(b_data),
    .rd_idx_i(tap_idx),
    .w_rd_o_c(w_rd_c),
    .bias_o  (bias_c)
  );

  // Unsigned pixel times signed weight, then sign-extended to the accumulator.
  always_comb begin
    pix_s_c    = PROD_W'({1'b0, pix_in});
    w_s_c      = PROD_W'(w_rd_c);
    prod_c     = pix_s_c * w_s_c;
    prod_ext_c = ACC_W'(prod_c);
    sum_c      = SUM_W'(acc_q) + SUM_W'(bias_c);
    shifted_c  = sum_c >>> SHIFT;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    exp_tap_d    = exp_tap_q;
    win_cnt_d    = win_cnt_q;
    res_data_d   = res_data_q;
    frame_done_d = 1'b0;
    sat_d        = sat_q;
    seq_err_d    = seq_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (tap_idx == 4'd0) begin
            acc_d     = prod_ext_c;
            exp_tap_d = 4'd1;
            state_d   = ACCUM;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (accept_c) begin
          if (tap_idx == exp_tap_q) begin
            acc_d = acc_q + prod_ext_c;
            if (exp_tap_q == 4'(NUM_TAPS - 1)) begin
              state_d = FINISH;
            end else begin
              exp_tap_d = exp_tap_q + 4'd1;
            end
          end else begin
            // Out-of-order tap: abandon the partial window.
            seq_err_d = 1'b1;
            acc_d     = '0;
            exp_tap_d = 4'd0;
            state_d   = IDLE;
          end
        end
      end
      FINISH: begin
        if (shifted_c > SUM_W'(SAT_MAX)) begin
          res_data_d = 8'(SAT_MAX);
          sat_d      = 1'b1;
        end else if (shifted_c < SUM_W'(SAT_MIN)) begin
          res_data_d = 8'(SAT_MIN);
          sat_d      = 1'b1;
        end else begin
          res_data_d = 8'(shifted_c);
        end
        acc_d     = '0;
        exp_tap_d = 4'd0;
        state_d   = OUT;
      end
      OUT: begin
        if (hs_c) begin
          state_d = IDLE;
          if (win_cnt_q == CNT_W'(IMG_PIXELS - 1)) begin
            win_cnt_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state.
    pix_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    res_valid_d = (state_d == OUT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      exp_tap_q    <= 4'd0;
      win_cnt_q    <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      pix_ready_q  <= 1'b1;
      frame_done_q <= 1'b0;
      sat_q        <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      exp_tap_q    <= exp_tap_d;
      win_cnt_q    <= win_cnt_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      pix_ready_q  <= pix_ready_d;
      frame_done_q <= frame_done_d;
      sat_q        <= sat_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign res_data   = res_data_q;
  assign res_valid  = res_valid_q;
  assign frame_done = frame_done_q;
  assign sat_flag   = sat_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_conv3x3_mac.sv
// Scoreboard bench for conv3x3_mac: the driver pushes hand-computed results,
// a monitor pops and compares on every result handshake and tracks frame_done.
module tb_conv3x3_mac;

  typedef logic [7:0] pvec_t [9];
  typedef logic [7:0] wvec_t [9];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pix_in = '0;
  logic [3:0]  tap_idx = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        w_load = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [7:0]  w_data = '0;
  logic        b_load = 1'b0;
  logic [23:0] b_data = '0;
  logic [7:0]  res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        frame_done;
  logic        sat_flag;
  logic        seq_err;

  conv3x3_mac #(.IMG_PIXELS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_in    (pix_in),
    .tap_idx   (tap_idx),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .w_load    (w_load),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_load    (b_load),
    .b_data    (b_data),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .frame_done(frame_done),
    .sat_flag  (sat_flag),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int fd_pulses = 0;
  int hs_cnt = 0;
  bit fd_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares results on handshake and expects frame_done after every 4th.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        hs_cnt = 0;
        fd_exp = 1'b0;
      end else begin
        if (frame_done || fd_exp) chk("frame_done", 32'(frame_done), 32'(fd_exp));
        if (frame_done) fd_pulses++;
        fd_exp = 1'b0;
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0h expected none", res_data);
          end else begin
            chk("res_data", 32'(res_data), 32'(exp_q.pop_front()));
          end
          hs_cnt++;
          if (hs_cnt == 4) begin
            hs_cnt = 0;
            fd_exp = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_pix(input logic [7:0] p, input logic [3:0] t);
    int n = 0;
    while (!pix_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      checks++;
      errors++;
      $display("FAIL pix_ready_timeout: got 0 expected 1");
    end
    pix_in = p;
    tap_idx = t;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic load_w(input int a, input logic [7:0] d);
    w_load = 1'b1;
    w_addr = 4'(a);
    w_data = d;
    @(negedge clk);
    w_load = 1'b0;
  endtask

  task automatic load_b(input logic [23:0] d);
    b_load = 1'b1;
    b_data = d;
    @(negedge clk);
    b_load = 1'b0;
  endtask

  task automatic load_uniform(input logic [7:0] w, input logic [23:0] b);
    for (int i = 0; i < 9; i++) load_w(i, w);
    load_b(b);
  endtask

  task automatic uniform_pix(input logic [7:0] v, output pvec_t p);
    for (int i = 0; i < 9; i++) p[i] = v;
  endtask

  // Full window; optional latency check: FINISH cycle then res_valid.
  task automatic run_window(input pvec_t p, input logic [7:0] exp, input bit lat);
    exp_q.push_back(exp);
    for (int i = 0; i < 9; i++) send_pix(p[i], 4'(i));
    if (lat) begin
      chk("lat_n1_valid", 32'(res_valid), 32'd0);
      chk("lat_n1_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
      chk("lat_n2_valid", 32'(res_valid), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !pix_ready || res_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy expected idle");
    end
  endtask

  initial begin : driver
    pvec_t p;
    wvec_t wv;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_seq", 32'(seq_err), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);

    // w=1, b=0, pix=255: 2295>>8 = 8
    load_uniform(8'd1, 24'd0);
    uniform_pix(8'd255, p);
    run_window(p, 8'd8, 1'b1);
    wait_idle();
    chk("sat_after_8", 32'(sat_flag), 32'd0);

    // w=127: 291465>>8 = 1138 -> 127
    load_uniform(8'd127, 24'd0);
    run_window(p, 8'h7F, 1'b0);
    wait_idle();
    chk("sat_after_pos", 32'(sat_flag), 32'd1);

    // w=-128: -293760>>8 = -1148 -> -128
    load_uniform(8'h80, 24'd0);
    run_window(p, 8'h80, 1'b0);
    wait_idle();

    // w=0, b=1280 -> 5; b=-1 -> floor -1
    load_uniform(8'd0, 24'd1280);
    run_window(p, 8'd5, 1'b0);
    wait_idle();
    load_b(24'hFFFFFF);
    run_window(p, 8'hFF, 1'b0);
    wait_idle();
    chk("sat_sticky", 32'(sat_flag), 32'd1);
    chk("seq_clear", 32'(seq_err), 32'd0);

    // Taps 0,1,3: sequence error, no output
    send_pix(8'd255, 4'd0);
    send_pix(8'd255, 4'd1);
    send_pix(8'd255, 4'd3);
    chk("seq_set", 32'(seq_err), 32'd1);
    chk("seq_idle_ready", 32'(pix_ready), 32'd1);
    repeat (4) @(negedge clk);

    // w = -4..4, b = 100, pix = 10..90: 600+100=700>>8 = 2
    wv = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 9; i++) load_w(i, wv[i]);
    load_b(24'd100);
    p = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    run_window(p, 8'd2, 1'b0);
    wait_idle();

    // Backpressure: 255*(1+2+3+4)+100 = 2650>>8 = 10; loads in OUT ignored
    p = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
    res_ready = 1'b0;
    run_window(p, 8'd10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", 32'(res_data), 32'd10);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_ready", 32'(pix_ready), 32'd0);
      if (i == 0) begin
        w_load = 1'b1;
        w_addr = 4'd5;
        w_data = 8'd50;
        b_load = 1'b1;
        b_data = 24'd5000;
      end else begin
        w_load = 1'b0;
        b_load = 1'b0;
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    wait_idle();
    run_window(p, 8'd10, 1'b0);
    wait_idle();
    chk("seq_sticky", 32'(seq_err), 32'd1);

    // Reset after tap 4 discards the window and clears flags/weights
    for (int i = 0; i < 5; i++) send_pix(8'd200, 4'(i));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_ready", 32'(pix_ready), 32'd1);
    chk("mid_rst_seq", 32'(seq_err), 32'd0);
    chk("mid_rst_sat", 32'(sat_flag), 32'd0);
    repeat (4) @(negedge clk);

    // w=2, b=0; w_addr 9 and 15 ignored. pix 100/20/40/60 -> 7,1,2,4; frame_done on 4th
    load_uniform(8'd2, 24'd0);
    load_w(9, 8'd100);
    load_w(15, 8'd100);
    uniform_pix(8'd100, p);
    run_window(p, 8'd7, 1'b0);
    wait_idle();
    uniform_pix(8'd20, p);
    run_window(p, 8'd1, 1'b0);
    wait_idle();
    uniform_pix(8'd40, p);
    run_window(p, 8'd2, 1'b0);
    wait_idle();
    uniform_pix(8'd60, p);
    run_window(p, 8'd4, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("fd_pulses", 32'(fd_pulses), 32'd3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, pixel width (unsigned); W_W, default 8, weight width (signed); ACC_W, default 24, accumulator and bias width (signed); SHIFT, default 8, output right-shift; IMG_PIXELS, default 409600, windows per frame.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high.
- pix_in, in, DATA_W: pixel read from image memory.
- tap_idx, in, 4: window tap index 0..8, from the window FSM.
- pix_valid, in, 1: pix_in and tap_idx are valid.
- pix_ready, out, 1: block accepts a pixel this cycle.
- w_load, in, 1: weight write strobe.
- w_addr, in, 4: weight index 0..8.
- w_data, in, W_W: signed weight value.
- b_load, in, 1: bias write strobe.
- b_data, in, ACC_W: signed bias value.
- res_data, out, 8: signed saturated result.
- res_valid, out, 1: result available.
- res_ready, in, 1: downstream accepts the result.
- frame_done, out, 1: one-cycle pulse on the last window of a frame.
- sat_flag, out, 1: sticky; a result saturated.
- seq_err, out, 1: sticky; tap order violation.

Function
REQ-003 A pixel SHALL be accepted only on a cycle where pix_valid and pix_ready are both high.
REQ-004 The FSM SHALL have four states: IDLE, ACCUM, FINISH, OUT. pix_ready SHALL be high only in IDLE and ACCUM.
REQ-005 In IDLE, an accepted pixel with tap_idx=0 SHALL load acc = pix*w[0] and move to ACCUM with expected tap 1. An accepted pixel with any other tap_idx SHALL be dropped and SHALL set seq_err.
REQ-006 In ACCUM, an accepted pixel with tap_idx equal to the expected tap SHALL add pix*w[tap] to acc. On tap 8 the FSM SHALL go to FINISH; otherwise expected tap SHALL increment.
REQ-007 In ACCUM, a tap mismatch SHALL set seq_err, discard the partial window, clear acc and return to IDLE; the offending pixel SHALL be dropped.
REQ-008 Product arithmetic: the pixel SHALL be zero-extended to a signed value and multiplied by the signed weight; the product SHALL be sign-extended to ACC_W before accumulation.
REQ-009 In FINISH, the block SHALL compute sum = acc + bias at ACC_W+1 bits, arithmetic shift right by SHIFT (floor), and saturate to [-128, 127]. sat_flag SHALL be set when clamping occurs. The result SHALL be registered into res_data and the FSM SHALL go to OUT.
REQ-010 Latency: tap 8 accepted at cycle N -> res_valid high at cycle N+2.
REQ-011 In OUT, res_valid SHALL be high and res_data SHALL be held stable until res_ready is high. On the handshake the FSM SHALL return to IDLE the next cycle.
REQ-012 A window counter SHALL increment on each result handshake. On the handshake where the count equals IMG_PIXELS-1, the counter SHALL wrap to 0 and frame_done SHALL pulse for one cycle.
REQ-013 w_load and b_load SHALL take effect only in IDLE and SHALL be ignored in all other states. If w_load and b_load are high in the same cycle, both SHALL be written.
REQ-014 A w_addr value greater than 8 SHALL be ignored.
REQ-015 sat_flag and seq_err SHALL clear only on reset.

Reset
REQ-016 On reset: state=IDLE, acc=0, expected tap=0, window counter=0, res_data=0, res_valid=0, frame_done=0, sat_flag=0, seq_err=0, pix_ready=1 from the first cycle after reset.
REQ-017 On reset: weights=0 and bias=0.
REQ-018 Reset asserted mid-window or in OUT SHALL discard all in-flight data; no result SHALL be emitted for that window.

Structure
REQ-019 Shared package cbs_pkg SHALL hold the DATA_W, W_W, ACC_W, SHIFT and IMG_PIXELS defaults, the FSM state enum, and the saturation limits.
REQ-020 Sub-module conv_weight_rf SHALL hold the 9 weights and the bias, with synchronous write and combinational read by tap index; all other logic SHALL be in conv3x3_mac.

Verification
REQ-021 Weights all 1, bias 0, nine pixels of 255 with taps 0..8 -> res_data=8, res_valid at N+2, sat_flag=0.
REQ-022 Weights all 127, pixels 255 -> res_data=127, sat_flag=1. Weights all -128, pixels 255 -> res_data=-128.
REQ-023 Weights 0, bias 1280 -> res_data=5. Weights 0, bias -1 -> res_data=-1 (floor).
REQ-024 Taps 0,1,3 -> seq_err=1 and no res_valid. The following clean window 0..8 -> correct result.
REQ-025 Hold res_ready low for 5 cycles in OUT -> res_data stable and pix_ready=0 throughout. Reset asserted after tap 4 -> no result; next window correct.
REQ-026 IMG_PIXELS=4, run 4 windows -> frame_done pulses once, on the 4th handshake, and the counter reads 0.
